// File: rtl/aip_bridge_pkg.sv
// Shared definitions for the picorv32-to-AIP host bridge.
// Holds register offsets, CTRL/STATUS bit positions, the bridge FSM
// state encoding and the AIP configuration selector width.
package aip_bridge_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned CONF_WIDTH = 5;
  localparam int unsigned LAT_CNT_W  = 2;

  // Word offsets inside the 16-byte window (mem_addr[3:2])
  localparam logic [1:0] OFF_CONFIG = 2'd0;
  localparam logic [1:0] OFF_DATA   = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // CTRL register bits
  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned CTRL_EN_BIT     = 2;

  // STATUS register bits
  localparam int unsigned STATUS_PEND_BIT   = 0;
  localparam int unsigned STATUS_IRQ_EN_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_PULSE = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

endpackage

// File: rtl/aip_bridge_irq.sv
// Interrupt block of the AIP host bridge: rising-edge detect on the AIP
// interrupt level, sticky pending flag, CPU mask and registered irq.
// Ports:
//   clk, rst_a  clock and synchronous active-high reset
//   int_req     AIP interrupt request level
//   en_wr       CTRL write strobe, loads irq_en from en_val
//   en_val      new irq_en value
//   clr         STATUS write with bit0 set; clears pending
//   irq_en      current mask bit
//   pending     sticky interrupt flag
//   irq         registered pending & irq_en
module aip_bridge_irq (
  input  logic clk,
  input  logic rst_a,
  input  logic int_req,
  input  logic en_wr,
  input  logic en_val,
  input  logic clr,
  output logic irq_en,
  output logic pending,
  output logic irq
);

  logic int_req_prev;
  logic rise_c;

  assign rise_c = int_req & ~int_req_prev;

  // A new edge in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk) begin
    if (rst_a) begin
      int_req_prev <= 1'b0;
      pending      <= 1'b0;
      irq_en       <= 1'b0;
      irq          <= 1'b0;
    end else begin
      int_req_prev <= int_req;
      if (rise_c) begin
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end
      if (en_wr) begin
        irq_en <= en_val;
      end
      irq <= pending & irq_en;
    end
  end

endmodule

// File: rtl/aip_host_bridge.sv
// Memory-mapped slave bridging the picorv32 native memory bus to the AIP
// protocol port. CPU loads/stores in a 4-word window become single-cycle
// AIP write/read/start pulses; the AIP interrupt is latched into irq.
// Optional feature macro: AIP_BRIDGE_IRQ_EN (interrupt logic present).
// Ports:
//   clk, rst_a                 clock, synchronous active-high reset
//   mem_valid/addr/wdata/wstrb picorv32 request
//   mem_ready/mem_rdata        one-cycle acknowledge and read data
//   aip_en_s, aip_data_in, aip_conf_dbus, aip_write, aip_read, aip_start
//                              AIP control outputs
//   aip_data_out, aip_int_req  AIP inputs
//   irq                        interrupt to CPU
module aip_host_bridge
  import aip_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  aip_en_s,
  output logic [DATA_WIDTH-1:0] aip_data_in,
  input  logic [DATA_WIDTH-1:0] aip_data_out,
  output logic [CONF_WIDTH-1:0] aip_conf_dbus,
  output logic                  aip_write,
  output logic                  aip_read,
  output logic                  aip_start,
  input  logic                  aip_int_req,
  output logic                  irq
);

  state_t state_q, state_nx;
  logic [LAT_CNT_W-1:0] lat_cnt_q;

  logic hit_c, is_wr_c, accept_c, data_rd_c, rd_done_c;
  logic [1:0] off_c;
  logic ctrl_wr_c, status_wr_c;
  logic irq_en_c, pending_c;

  logic                  ready_nx, write_nx, read_nx, start_nx, en_nx;
  logic [DATA_WIDTH-1:0] rdata_nx, data_in_nx;
  logic [CONF_WIDTH-1:0] conf_nx;

  logic unused_addr;
  assign unused_addr = ^mem_addr[1:0];

  // Request decode
  assign hit_c     = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign off_c     = mem_addr[3:2];
  assign is_wr_c   = |mem_wstrb;
  assign accept_c  = (state_q == ST_IDLE) && mem_valid && hit_c && !mem_ready;
  assign data_rd_c = !is_wr_c && (off_c == OFF_DATA);
  assign rd_done_c = (state_q == ST_RD_WAIT) &&
                     (lat_cnt_q == LAT_CNT_W'(READ_LAT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst_a) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE:     if (accept_c) state_nx = data_rd_c ? ST_RD_PULSE : ST_RESP;
      ST_RD_PULSE: state_nx = ST_RD_WAIT;
      ST_RD_WAIT:  if (rd_done_c) state_nx = ST_RESP;
      ST_RESP:     state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // Read latency counter, runs only while waiting on AIP data
  always_ff @(posedge clk) begin
    if (rst_a) begin
      lat_cnt_q <= '0;
    end else if (state_q == ST_RD_WAIT) begin
      lat_cnt_q <= lat_cnt_q + LAT_CNT_W'(1);
    end else begin
      lat_cnt_q <= '0;
    end
  end

  // Output/next-register logic; everything here lands in a register
  always_comb begin
    ready_nx    = 1'b0;
    write_nx    = 1'b0;
    read_nx     = 1'b0;
    start_nx    = 1'b0;
    en_nx       = aip_en_s;
    rdata_nx    = mem_rdata;
    data_in_nx  = aip_data_in;
    conf_nx     = aip_conf_dbus;
    ctrl_wr_c   = 1'b0;
    status_wr_c = 1'b0;

    if (accept_c) begin
      if (is_wr_c) begin
        ready_nx = 1'b1;
        case (off_c)
          OFF_CONFIG: conf_nx = mem_wdata[CONF_WIDTH-1:0];
          OFF_DATA: begin
            write_nx   = 1'b1;
            data_in_nx = mem_wdata;
          end
          OFF_CTRL: begin
            start_nx  = mem_wdata[CTRL_START_BIT];
            en_nx     = mem_wdata[CTRL_EN_BIT];
            ctrl_wr_c = 1'b1;
          end
          OFF_STATUS: status_wr_c = 1'b1;
          default: ;
        endcase
      end else begin
        ready_nx = (off_c != OFF_DATA);
        case (off_c)
          OFF_CONFIG: rdata_nx = DATA_WIDTH'(aip_conf_dbus);
          OFF_DATA:   read_nx  = 1'b1;
          OFF_CTRL: begin
            rdata_nx                  = '0;
            rdata_nx[CTRL_EN_BIT]     = aip_en_s;
            rdata_nx[CTRL_IRQ_EN_BIT] = irq_en_c;
          end
          OFF_STATUS: begin
            rdata_nx                    = '0;
            rdata_nx[STATUS_IRQ_EN_BIT] = irq_en_c;
            rdata_nx[STATUS_PEND_BIT]   = pending_c;
          end
          default: ;
        endcase
      end
    end

    if (rd_done_c) begin
      ready_nx = 1'b1;
      rdata_nx = aip_data_out;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst_a) begin
      mem_ready     <= 1'b0;
      mem_rdata     <= '0;
      aip_write     <= 1'b0;
      aip_read      <= 1'b0;
      aip_start     <= 1'b0;
      aip_en_s      <= 1'b0;
      aip_data_in   <= '0;
      aip_conf_dbus <= '0;
    end else begin
      mem_ready     <= ready_nx;
      mem_rdata     <= rdata_nx;
      aip_write     <= write_nx;
      aip_read      <= read_nx;
      aip_start     <= start_nx;
      aip_en_s      <= en_nx;
      aip_data_in   <= data_in_nx;
      aip_conf_dbus <= conf_nx;
    end
  end

`ifdef AIP_BRIDGE_IRQ_EN
  aip_bridge_irq u_irq (
    .clk     (clk),
    .rst_a   (rst_a),
    .int_req (aip_int_req),
    .en_wr   (ctrl_wr_c),
    .en_val  (mem_wdata[CTRL_IRQ_EN_BIT]),
    .clr     (status_wr_c & mem_wdata[STATUS_PEND_BIT]),
    .irq_en  (irq_en_c),
    .pending (pending_c),
    .irq     (irq)
  );
`else
  // Interrupt path absent: mask/pending read as zero, writes are dropped
  logic unused_irq;
  assign unused_irq = ^{ctrl_wr_c, status_wr_c, aip_int_req};
  assign irq_en_c   = 1'b0;
  assign pending_c  = 1'b0;
  assign irq        = 1'b0;
`endif

endmodule

// File: doc/aip_host_bridge.md
# aip_host_bridge

Memory-mapped slave that bridges the picorv32 native memory interface to the AIP protocol port of an accelerator wrapper: `data_in`, `data_out`, `conf_dbus`, `write`, `read`, `start` and `int_req`. It sits directly upstream of the AIP wrapper and turns CPU loads and stores in a 4-word window into single-cycle AIP `write`, `read` and `start` pulses. It also latches the AIP interrupt into a CPU-visible, maskable `irq`.

## Interface
Parameters:
- BASE_ADDR, 32'h8000_0000, word-aligned base of the 16-byte register window
- READ_LAT, 1, cycles from `aip_read` pulse to valid `aip_data_out` (range 1..4)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_a  in  1  reset, synchronous, active-high
- mem_valid  in  1  picorv32 request valid
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; nonzero means write, zero means read
- mem_ready  out  1  one-cycle acknowledge
- mem_rdata  out  32  read data, valid while mem_ready=1
- aip_en_s  out  1  AIP enable
- aip_data_in  out  32  data to AIP
- aip_data_out  in  32  data from AIP
- aip_conf_dbus  out  5  AIP configuration selector
- aip_write  out  1  AIP write pulse
- aip_read  out  1  AIP read pulse
- aip_start  out  1  AIP start pulse
- aip_int_req  in  1  AIP interrupt request (level)
- irq  out  1  interrupt to CPU

## Operation
- Decode: hit when mem_addr[31:4]==BASE_ADDR[31:4].
  - Offset = mem_addr[3:2].
  - Misses are ignored and mem_ready stays 0.
- Register map:
  - 0 CONFIG rw: conf_dbus <= wdata[4:0].
  - 1 DATA: write pulses aip_write with aip_data_in=wdata; read pulses aip_read and returns aip_data_out.
  - 2 CTRL: write bit0=1 → aip_start pulse (self-clearing); bit1 irq_en; bit2 aip_en_s. Read returns {29'b0, en, irq_en, 1'b0}.
  - 3 STATUS: read {30'b0, irq_en, pending}. Write bit0=1 clears pending.
- Any nonzero wstrb is a full-word write; byte strobes are not honoured.
- FSM states:
  - IDLE: accept when mem_valid & hit & !mem_ready.
    - DATA read → RD_PULSE.
    - Every other access → RESP.
  - RD_PULSE: aip_read=1 → RD_WAIT.
  - RD_WAIT: count READ_LAT−1 cycles, then capture aip_data_out into mem_rdata → RESP.
  - RESP: mem_ready=1 → IDLE.
- aip_data_in holds its last written value. aip_conf_dbus holds until the next CONFIG write.
- Interrupt handling:
  - pending sets on a rising edge of aip_int_req, detected against a registered previous value.
  - Clear via STATUS write. Set and clear in the same cycle → set wins.
  - irq = pending & irq_en, registered.
- All outputs registered. Reset values:
  - mem_ready, aip_write, aip_read, aip_start, aip_en_s, irq: 0
  - mem_rdata, aip_data_in: 0; aip_conf_dbus: 5'd0
  - irq_en, pending, edge register: 0; FSM: IDLE
- Reset mid-transaction aborts it: no mem_ready and no pending AIP pulse is issued. The CPU must be reset with the bridge.

## Timing
- Request accepted at edge E0 (cycle 0).
- Write or non-DATA read: AIP pulse (if any) and mem_ready both high in cycle 1, each for exactly one cycle.
- DATA read:
  - aip_read high in cycle 1.
  - aip_data_out sampled at the end of cycle 1+READ_LAT.
  - mem_ready and mem_rdata in cycle 2+READ_LAT. With READ_LAT=1 that is cycle 3.
- Back-to-back: the next request is accepted no earlier than the cycle after mem_ready, so AIP pulses are separated by ≥1 idle cycle.
- irq asserts 2 cycles after the aip_int_req rising edge: edge detect, then irq register.

## Configuration
- AIP_BRIDGE_IRQ_EN defined: interrupt logic as above.
- Undefined:
  - Edge detect, pending and irq_en are removed.
  - irq is tied 0.
  - STATUS and CTRL bit1 read 0, and writes to them are ignored.
  - Accesses are still acknowledged with unchanged timing.

## Structure
- Package aip_bridge_pkg holds:
  - Register offsets (CONFIG=0, DATA=1, CTRL=2, STATUS=3)
  - CTRL bit indices
  - FSM state enum
  - CONF_WIDTH=5
- One sub-module, aip_bridge_irq: edge detect, pending flag, mask and registered irq. It is instantiated only under AIP_BRIDGE_IRQ_EN.

## Test plan
- Store 0x0000_0003 to BASE+0 → aip_conf_dbus=5'd3 from cycle 1; mem_ready pulses in cycle 1; read of BASE+0 returns 3.
- Store 0xDEAD_BEEF to BASE+4 → aip_write=1 and aip_data_in=0xDEADBEEF in cycle 1 only; no aip_read.
- Load BASE+4 with aip_data_out=0x1234_5678 from cycle 2, READ_LAT=1 → aip_read in cycle 1; mem_ready in cycle 3 with mem_rdata=0x12345678.
- Store 0x6 then 0x7 to BASE+8 → aip_en_s=1 and irq_en=1; exactly one aip_start pulse, which follows the second store.
- Raise aip_int_req → irq=1 two cycles later. Store 1 to BASE+12 on the same cycle as a new rising edge → pending stays 1. Store 1 to BASE+12 again → irq=0.
- Assert rst_a during RD_WAIT → no mem_ready; all outputs at reset values the next cycle; access to BASE+0x10 never acknowledged.
